// File: rtl/fetch_unit_if.sv
// Instruction-memory request/valid bus between the fetch stage and imem.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    // Fetch stage drives the address/request and consumes the returned word.
    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_valid
    );

    // Instruction memory answers a request with a word and a valid strobe.
    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: program counter, one-word fetch per issue,
// next-PC selection (jr / j / branch / sequential) and a retired counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master imem,
    input  logic         stall,
    input  logic         Branch,
    input  logic         Jump,
    input  logic         negzero,
    input  logic         zero,
    input  logic [31:0]  rs_data,
    output logic [31:0]  instr,
    output logic [5:0]   ins,
    output logic [5:0]   func,
    output logic         instr_valid,
    output logic [31:0]  pc_plus4,
    output logic [31:0]  icount,
    output logic         err_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_icount;
    logic        r_req;
    logic        r_instr_valid;
    logic        r_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic        w_is_jr;
    logic        w_br_taken;
    logic [31:0] w_next_pc;

    // Everything the decoder sees is taken straight from registers.
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_is_jr     = (r_instr[31:26] == 6'b000000) && (r_instr[5:0] == 6'b001000);
    assign w_br_taken  = Branch && (zero ^ negzero);

    // Next-PC selection: jr beats j/jal, which beats a taken branch.
    always_comb begin
        // NOTE: default first so every path assigns w_next_pc and no latch is inferred.
        w_next_pc = w_pc_plus4;
        if (w_is_jr) begin
            w_next_pc = {rs_data[31:2], 2'b00};
        end else if (Jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (w_br_taken) begin
            w_next_pc = w_pc_plus4 + w_br_offset;
        end
    end

    // Fetch FSM; req/valid are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_icount      <= 32'h0;
            r_req         <= 1'b0;
            r_instr_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        r_instr       <= imem.imem_rdata;
                        r_state       <= ST_ISSUE;
                        r_req         <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_icount      <= r_icount + 32'd1;
                        r_state       <= ST_FETCH;
                        r_req         <= 1'b1;
                        r_instr_valid <= 1'b0;
                        if (w_is_jr && (rs_data[1:0] != 2'b00)) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_req         <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_addr = r_pc;
    assign imem.imem_req  = r_req;
    assign pc_plus4       = w_pc_plus4;
    assign instr          = r_instr;
    assign ins            = r_instr[31:26];
    assign func           = r_instr[5:0];
    assign instr_valid    = r_instr_valid;
    assign icount         = r_icount;
    assign err_misalign   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed instructions push the expected
// next fetch address; a monitor pops it on every accepted fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic        negzero = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] instr;
    logic [5:0]  ins;
    logic [5:0]  func;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic [31:0] icount;
    logic        err_misalign;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_icount = 32'h0;
    logic        exp_err = 1'b0;
    int          mem_wait = 0;
    int          req_cnt = 0;
    int          waited;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (bus),
        .stall        (stall),
        .Branch       (Branch),
        .Jump         (Jump),
        .negzero      (negzero),
        .zero         (zero),
        .rs_data      (rs_data),
        .instr        (instr),
        .ins          (ins),
        .func         (func),
        .instr_valid  (instr_valid),
        .pc_plus4     (pc_plus4),
        .icount       (icount),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    // Memory model: answers after mem_wait request cycles.
    always @(posedge clk) req_cnt <= bus.imem_req ? req_cnt + 1 : 0;
    assign bus.imem_valid = bus.imem_req && (req_cnt >= mem_wait);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fetch must target the predicted address.
    always @(negedge clk) begin
        if (rst_n && bus.imem_req && bus.imem_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_unexpected: got fetch at %h expected none", bus.imem_addr);
            end else begin
                check("fetch_addr", bus.imem_addr, exp_q.pop_front());
            end
        end
    end

    // One instruction: serve the fetch, check the issue view, hold n_stall
    // cycles, then let it retire. Entered and left just after a rising edge.
    task automatic step(input string nm, input logic [31:0] word,
                        input logic br, input logic jp, input logic nz, input logic z,
                        input logic [31:0] rs, input int n_stall,
                        input logic [31:0] exp_next, output int n_wait);
        logic [31:0] pc_hold;
        int          i;
        bus.imem_rdata = word;
        Branch  = br;
        Jump    = jp;
        negzero = nz;
        zero    = z;
        rs_data = rs;
        stall   = (n_stall > 0);
        n_wait  = 0;
        for (i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_valid) break;
            if (bus.imem_req) n_wait++;
        end
        if (i == 64) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no fetch in %0d cycles expected one", nm, i);
        end
        pc_hold = bus.imem_addr;
        exp_q.push_back(exp_next);
        @(negedge clk);
        check({nm, "_valid"}, {31'h0, instr_valid}, 32'h1);
        check({nm, "_req"}, {31'h0, bus.imem_req}, 32'h0);
        check({nm, "_instr"}, instr, word);
        check({nm, "_ins"}, {26'h0, ins}, {26'h0, word[31:26]});
        check({nm, "_func"}, {26'h0, func}, {26'h0, word[5:0]});
        check({nm, "_pc4"}, pc_plus4, pc_hold + 32'd4);
        check({nm, "_icount"}, icount, exp_icount);
        check({nm, "_err"}, {31'h0, err_misalign}, {31'h0, exp_err});
        for (int k = 0; k < n_stall; k++) begin
            @(negedge clk);
            check({nm, "_stall_valid"}, {31'h0, instr_valid}, 32'h1);
            check({nm, "_stall_pc"}, bus.imem_addr, pc_hold);
            check({nm, "_stall_icount"}, icount, exp_icount);
        end
        stall = 1'b0;
        exp_icount = exp_icount + 32'd1;
        if (word[31:26] == 6'd0 && word[5:0] == 6'd8 && rs[1:0] != 2'b00) exp_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.imem_rdata = 32'h0;
        exp_q.push_back(32'h0);
        repeat (2) @(negedge clk);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_icount", icount, 32'h0);
        check("rst_err", {31'h0, err_misalign}, 32'h0);
        check("rst_ins", {26'h0, ins}, 32'h0);
        check("rst_func", {26'h0, func}, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        rst_n = 1'b1;
        #1;
        check("idle_req", {31'h0, bus.imem_req}, 32'h0);
        @(posedge clk);
        #1;
        check("fetch_req_2nd_cycle", {31'h0, bus.imem_req}, 32'h1);

        // Sequential fetch 0,4,8,C.
        step("seq0", 32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0004, waited);
        step("seq1", 32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0008, waited);
        step("seq2", 32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 32'h0000_000C, waited);
        step("seq3", 32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0010, waited);
        // jr to 0x100 (icount=4 checked here).
        step("jr100", 32'h03E0_0008, 0, 0, 0, 0, 32'h0000_0100, 0, 32'h0000_0100, waited);
        // beq taken backwards: 0x104 - 8.
        step("beq_t", 32'h1000_FFFE, 1, 0, 0, 1, 32'h0, 0, 32'h0000_00FC, waited);
        step("jr100b", 32'h03E0_0008, 0, 0, 0, 0, 32'h0000_0100, 0, 32'h0000_0100, waited);
        // Same branch with negzero: condition inverted, falls through.
        step("bne_nt", 32'h1000_FFFE, 1, 0, 1, 1, 32'h0, 0, 32'h0000_0104, waited);
        step("jr_hi", 32'h03E0_0008, 0, 0, 0, 0, 32'h0040_0010, 0, 32'h0040_0010, waited);
        step("jump", 32'h0810_0020, 0, 1, 0, 0, 32'h0, 0, 32'h0040_0080, waited);
        // jr wins over Jump; misaligned rs sets the sticky error.
        step("jr_mis", 32'h03E0_0008, 0, 1, 0, 0, 32'h0000_1236, 0, 32'h0000_1234, waited);
        // Three memory wait cycles plus five stall cycles.
        mem_wait = 3;
        step("wait_stall", 32'h0000_0000, 0, 0, 0, 0, 32'h0, 5, 32'h0000_1238, waited);
        check("wait_req_cycles", waited, 32'd3);
        mem_wait = 0;
        step("jr_top", 32'h03E0_0008, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, waited);
        // PC wraps to 0.
        step("wrap", 32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0000, waited);
        // Branch with zero=0: not taken.
        step("beq_nt", 32'h1000_0003, 1, 0, 0, 0, 32'h0, 0, 32'h0000_0004, waited);

        // Reset during FETCH with imem_valid high.
        rst_n = 1'b0;
        #1;
        check("rstF_req", {31'h0, bus.imem_req}, 32'h0);
        check("rstF_valid", {31'h0, instr_valid}, 32'h0);
        check("rstF_addr", bus.imem_addr, 32'h0);
        check("rstF_icount", icount, 32'h0);
        check("rstF_err", {31'h0, err_misalign}, 32'h0);
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_icount = 32'h0;
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", 32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0004, waited);

        // Reset during ISSUE.
        bus.imem_rdata = 32'h1000_0003;
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("preI_valid", {31'h0, instr_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstI_valid", {31'h0, instr_valid}, 32'h0);
        check("rstI_req", {31'h0, bus.imem_req}, 32'h0);
        check("rstI_instr", instr, 32'h0);
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_icount = 32'h0;
        exp_err = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("final", 32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0004, waited);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t expected earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS datapath. Holds the program counter, fetches one instruction per issue over a simple request/valid handshake with instruction memory, and presents the latched instruction plus its opcode/func fields to the decode/control stage. After each issue it computes the next PC from the control stage's Branch/Jump/negzero outputs, the ALU zero flag and jr detection. It also keeps a retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  fetch address; always equals the current PC.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_rdata  in  32  instruction word; sampled when imem_valid is high in FETCH.
- imem_valid  in  1  instruction-memory data valid.
- stall  in  1  downstream hold; blocks issue while high.
- Branch  in  1  branch instruction (from control).
- Jump  in  1  j/jal instruction (from control).
- negzero  in  1  invert branch condition (bne).
- zero  in  1  ALU zero flag for the issuing instruction.
- rs_data  in  32  register rs value, used by jr.
- instr  out  32  latched instruction word.
- ins  out  6  opcode, instr[31:26].
- func  out  6  function field, instr[5:0].
- instr_valid  out  1  instr/ins/func valid for decode.
- pc_plus4  out  32  PC+4 of the held instruction (jal link value).
- icount  out  32  retired-instruction count.
- err_misalign  out  1  sticky flag: a jr target had nonzero bits [1:0].

## Operation
- State machine with three states: IDLE, FETCH, ISSUE.
- IDLE is entered on reset. IDLE -> FETCH on the next edge, unconditionally.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_valid: instr <= imem_rdata, go to ISSUE.
  - Otherwise wait in FETCH with no timeout.
- ISSUE: instr_valid=1, imem_req=0.
  - If stall=1: hold; pc and instr are unchanged.
  - If stall=0 at the edge: pc <= next_pc, icount <= icount+1 (wraps at 2^32), go to FETCH.
- next_pc is combinational, using 32-bit modular arithmetic. Priority, highest first:
  1. jr, when ins=6'b000000 and func=6'b001000: {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, set err_misalign=1 at the issue edge.
  2. Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. Branch=1 and (zero XOR negzero): pc_plus4 + ({{14{instr[15]}},instr[15:0]} << 2).
  4. Otherwise: pc_plus4.
- pc_plus4 = pc + 4, wrapping from 32'hFFFF_FFFC to 0.
- err_misalign is cleared only by reset.
- imem_valid outside FETCH is ignored. Redirect inputs are ignored outside the ISSUE issue edge.

## Timing
- Reset values:
  - pc=RESET_PC, state=IDLE, instr=0, instr_valid=0, imem_req=0.
  - icount=0, err_misalign=0.
  - ins=0, func=0, imem_addr=RESET_PC, pc_plus4=RESET_PC+4.
- Reset is asynchronous: assertion mid-FETCH or mid-ISSUE drops imem_req and instr_valid immediately.
- After rst_n rises: 1 cycle in IDLE, then imem_req=1 on the second cycle.
- Minimum throughput: 2 cycles per instruction (FETCH with imem_valid in the same cycle, then ISSUE with stall=0).
- Each memory wait cycle and each stall cycle adds 1 cycle.
- instr_valid rises the cycle after imem_valid is sampled.
- All outputs are registered except next_pc-derived logic; imem_addr and pc_plus4 are decoded from the pc register.
- Downstream inputs (Branch, Jump, negzero, zero, rs_data) must be stable during ISSUE. They may depend combinationally on ins/func.

## Test plan
- Sequential fetch: reset with RESET_PC=0, imem_valid always 1, all redirects 0 -> imem_addr sequence 0,4,8,C at 2-cycle spacing; icount=4 after 4 issues.
- beq taken: at pc=0x100, instr=0x1000_FFFE, Branch=1, zero=1 -> next imem_addr=0xFC. Same with negzero=1 -> next imem_addr=0x104.
- Jump and jr priority: at pc=0x0040_0010, instr=0x0810_0020 with Jump=1 -> 0x0040_0080. Then jr instr 0x03E0_0008 with rs_data=0x1236 and Jump=1 -> target 0x1234, err_misalign=1.
- Stall and wait states: imem_valid delayed 3 cycles -> imem_req held 4 cycles. stall=1 for 5 cycles in ISSUE -> instr_valid held, pc unchanged, icount unchanged.
- Wrap: RESET_PC=32'hFFFF_FFFC, sequential issue -> next imem_addr=0.
- Reset mid-operation: assert rst_n=0 during FETCH with imem_valid=1 -> imem_req=0 and instr_valid=0 immediately. pc=RESET_PC and icount=0 after release.
